// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads fill whole blocks from a combinational block-read memory; stores go through as single words.
module data_cache_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 27,
  parameter int OFFSET_BITS   = 2,
  parameter int INDEX_BITS    = 4,
  parameter int MISS_LATENCY  = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cpu_req,
  input  logic                                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0]                 cpu_addr,
  input  logic [DATA_WIDTH-1:0]                    cpu_wdata,
  output logic                                     cpu_ready,
  output logic [DATA_WIDTH-1:0]                    cpu_rdata,
  output logic [ADDRESS_WIDTH-1:0]                 mem_addr,
  input  logic [DATA_WIDTH*(2**OFFSET_BITS)-1:0]   mem_read_data,
  output logic [DATA_WIDTH-1:0]                    mem_write_data,
  output logic                                     mem_write_enable,
  output logic [31:0]                              hit_count,
  output logic [31:0]                              miss_count,
  output logic [1:0]                               state_dbg
);

  localparam int BLOCK_WORDS = 2 ** OFFSET_BITS;
  localparam int LINES       = 2 ** INDEX_BITS;
  localparam int TAG_BITS    = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int CNT_W       = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RESPOND = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] cnt;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES][BLOCK_WORDS];

  logic [OFFSET_BITS-1:0] req_offset;
  logic [INDEX_BITS-1:0]  req_index;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   hit;
  logic                   fill_done;
  logic [DATA_WIDTH-1:0]  fill_word;

  assign req_offset = cpu_addr[OFFSET_BITS-1:0];
  assign req_index  = cpu_addr[OFFSET_BITS +: INDEX_BITS];
  assign req_tag    = cpu_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
  assign hit        = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign fill_done  = (state == FILL) && (cnt == '0);
  assign state_dbg  = state;

  always_comb begin
    fill_word = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      if (req_offset == OFFSET_BITS'(i)) fill_word = mem_read_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Handshake: the CPU holds cpu_req and all request fields stable until a cycle
  // with cpu_ready=1; that single cycle completes exactly one transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n          = state;
    cpu_ready        = 1'b0;
    mem_write_enable = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we)   state_n = WRITE;
          else if (hit) state_n = RESPOND;
          else          state_n = FILL;
        end
      end
      FILL: begin
        if (cnt == '0) state_n = RESPOND;
      end
      RESPOND: begin
        cpu_ready = 1'b1;
        state_n   = IDLE;
      end
      WRITE: begin
        cpu_ready        = 1'b1;
        mem_write_enable = 1'b1;
        state_n          = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      cpu_rdata      <= '0;
      valid          <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              mem_addr       <= cpu_addr;
              mem_write_data <= cpu_wdata;
            end else if (hit) begin
              cpu_rdata <= data_mem[req_index][req_offset];
              if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
              mem_addr <= {req_tag, req_index, {OFFSET_BITS{1'b0}}};
              cnt      <= CNT_W'(MISS_LATENCY - 1);
              if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
          end
        end
        FILL: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            valid[req_index] <= 1'b1;
            cpu_rdata        <= fill_word;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[req_index] <= req_tag;
      for (int w = 0; w < BLOCK_WORDS; w++) begin
        data_mem[req_index][w] <= mem_read_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if ((state == WRITE) && hit) begin
      data_mem[req_index][req_offset] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: miss/hit/store paths, conflict eviction and reset mid-fill.
module tb_data_cache_ctrl;

  logic         clk;
  logic         rst_n;
  logic         cpu_req;
  logic         cpu_we;
  logic [26:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic [26:0]  mem_addr;
  logic [127:0] mem_read_data;
  logic [31:0]  mem_write_data;
  logic         mem_write_enable;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [1:0]   state_dbg;

  logic [31:0] mem_words [0:1023];
  int total;
  int bad;

  data_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational block-read memory
  always @* begin
    for (int i = 0; i < 4; i++) begin
      mem_read_data[i*32 +: 32] = mem_words[{mem_addr[9:2], 2'b00} + 10'(i)];
    end
  end

  task automatic do_reset();
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one request, watches the outputs at each falling edge until cpu_ready.
  // lat counts the presenting cycle as 1; wait_cyc counts cycles spent before cpu_ready.
  task automatic cpu_access(input logic we, input logic [26:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rd, output int wait_cyc,
                            output logic [26:0] held_addr, output logic held_ok,
                            output int we_cnt, output logic [26:0] wr_addr, output logic [31:0] wr_data);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = 1; wait_cyc = 0; held_ok = 1'b1; we_cnt = 0;
    held_addr = '0; wr_addr = '0; wr_data = '0; rd = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_write_enable) begin
        we_cnt++;
        wr_addr = mem_addr;
        wr_data = mem_write_data;
        mem_words[mem_addr[9:0]] = mem_write_data;
      end
      if (cpu_ready) begin
        rd = cpu_rdata;
        break;
      end
      if (wait_cyc == 0) held_addr = mem_addr;
      else if (mem_addr !== held_addr) held_ok = 1'b0;
      wait_cyc++;
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  int lat, wait_cyc, we_cnt;
  logic [31:0] rd, wr_data;
  logic [26:0] held_addr, wr_addr;
  logic held_ok;

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", cpu_ready); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", cpu_rdata); end
    total++; if (mem_addr !== 27'h0) begin bad++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h exp=0", mem_write_enable); end
    total++; if (mem_write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", mem_write_data); end
    total++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_fill();
    cpu_access(1'b0, 27'h5, 32'h0, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (lat !== 4) begin bad++; $display("FAIL miss_latency got=%0d exp=4", lat); end
    total++; if (rd !== 32'hBB) begin bad++; $display("FAIL miss_rdata got=%0h exp=bb", rd); end
    total++; if (wait_cyc !== 2 || held_addr !== 27'h4 || held_ok !== 1'b1) begin
      bad++; $display("FAIL miss_mem_addr got=%0h cycles=%0d stable=%0d exp=4 cycles=2 stable=1", held_addr, wait_cyc, held_ok);
    end
    total++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin bad++; $display("FAIL miss_counts got=%0d/%0d exp=0/1", hit_count, miss_count); end
  endtask

  task automatic test_hit();
    cpu_access(1'b0, 27'h7, 32'h0, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (lat !== 2) begin bad++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    total++; if (rd !== 32'hDD) begin bad++; $display("FAIL hit_rdata got=%0h exp=dd", rd); end
    total++; if (mem_addr !== 27'h4) begin bad++; $display("FAIL hit_mem_addr got=%0h exp=4", mem_addr); end
    total++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin bad++; $display("FAIL hit_counts got=%0d/%0d exp=1/1", hit_count, miss_count); end
    @(negedge clk);
    total++; if (cpu_rdata !== 32'hDD) begin bad++; $display("FAIL rdata_hold got=%0h exp=dd", cpu_rdata); end
  endtask

  task automatic test_store_hit();
    cpu_access(1'b1, 27'h6, 32'h12345678, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (lat !== 2) begin bad++; $display("FAIL store_latency got=%0d exp=2", lat); end
    total++; if (we_cnt !== 1 || wr_addr !== 27'h6 || wr_data !== 32'h12345678) begin
      bad++; $display("FAIL store_write got=%0d@%0h=%0h exp=1@6=12345678", we_cnt, wr_addr, wr_data);
    end
    @(negedge clk);
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL store_we_drop got=%0h exp=0", mem_write_enable); end
    cpu_access(1'b0, 27'h6, 32'h0, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (lat !== 2 || rd !== 32'h12345678) begin bad++; $display("FAIL store_reload got=%0h lat=%0d exp=12345678 lat=2", rd, lat); end
    total++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin bad++; $display("FAIL store_counts got=%0d/%0d exp=2/1", hit_count, miss_count); end
  endtask

  task automatic test_store_miss();
    cpu_access(1'b1, 27'h100, 32'hCAFEF00D, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (we_cnt !== 1 || wr_addr !== 27'h100 || wr_data !== 32'hCAFEF00D) begin
      bad++; $display("FAIL nwa_write got=%0d@%0h=%0h exp=1@100=cafef00d", we_cnt, wr_addr, wr_data);
    end
    total++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin bad++; $display("FAIL nwa_store_counts got=%0d/%0d exp=2/1", hit_count, miss_count); end
    cpu_access(1'b0, 27'h100, 32'h0, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (lat !== 4 || rd !== 32'hCAFEF00D) begin bad++; $display("FAIL nwa_load got=%0h lat=%0d exp=cafef00d lat=4", rd, lat); end
    total++; if (held_addr !== 27'h100 || miss_count !== 32'd2) begin bad++; $display("FAIL nwa_fill got=%0h miss=%0d exp=100 miss=2", held_addr, miss_count); end
  endtask

  task automatic test_conflict();
    do_reset();
    cpu_access(1'b0, 27'h4, 32'h0, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (lat !== 4 || rd !== 32'hAA || held_addr !== 27'h4) begin bad++; $display("FAIL conflict_a got=%0h lat=%0d addr=%0h exp=aa lat=4 addr=4", rd, lat, held_addr); end
    cpu_access(1'b0, 27'h44, 32'h0, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (lat !== 4 || rd !== 32'h11 || held_addr !== 27'h44) begin bad++; $display("FAIL conflict_b got=%0h lat=%0d addr=%0h exp=11 lat=4 addr=44", rd, lat, held_addr); end
    cpu_access(1'b0, 27'h4, 32'h0, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (lat !== 4 || rd !== 32'hAA || held_addr !== 27'h4) begin bad++; $display("FAIL conflict_c got=%0h lat=%0d addr=%0h exp=aa lat=4 addr=4", rd, lat, held_addr); end
    total++; if (miss_count !== 32'd3 || hit_count !== 32'd0) begin bad++; $display("FAIL conflict_counts got=%0d/%0d exp=0/3", hit_count, miss_count); end
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 27'h45; cpu_wdata = 32'h0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0 || mem_addr !== 27'h0) begin
      bad++; $display("FAIL midfill_outputs got=%0h/%0h/%0h exp=0/0/0", cpu_ready, cpu_rdata, mem_addr);
    end
    total++; if (mem_write_enable !== 1'b0 || mem_write_data !== 32'h0 || state_dbg !== 2'd0) begin
      bad++; $display("FAIL midfill_write_state got=%0h/%0h/%0d exp=0/0/0", mem_write_enable, mem_write_data, state_dbg);
    end
    total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL midfill_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_access(1'b0, 27'h45, 32'h0, lat, rd, wait_cyc, held_addr, held_ok, we_cnt, wr_addr, wr_data);
    total++; if (lat !== 4 || rd !== 32'h22) begin bad++; $display("FAIL midfill_reload got=%0h lat=%0d exp=22 lat=4", rd, lat); end
    total++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin bad++; $display("FAIL midfill_restart got=%0d/%0d exp=0/1", hit_count, miss_count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 1024; i++) mem_words[i] = 32'h0;
    mem_words[4] = 32'hAA; mem_words[5] = 32'hBB; mem_words[6] = 32'hCC; mem_words[7] = 32'hDD;
    mem_words[10'h44] = 32'h11; mem_words[10'h45] = 32'h22;
    mem_words[10'h46] = 32'h33; mem_words[10'h47] = 32'h44;
    mem_words[10'h100] = 32'h0BADBEEF;
    test_reset();
    test_miss_fill();
    test_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store stage and the block-read data memory.
- It is the initiator of the memory's interface. Reads fetch a whole block from the memory on a miss. Writes are forwarded as single words.
- The memory read port is combinational with a fixed settle budget, so the cache times fills with a latency counter rather than a handshake.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDRESS_WIDTH, 27, CPU word-address width.
- OFFSET_BITS, 2, log2 of words per block. BLOCK_WORDS = 2**OFFSET_BITS.
- INDEX_BITS, 4, log2 of number of lines (16 lines).
- MISS_LATENCY, 2, cycles mem_addr is held before mem_read_data is sampled. Must be at least 1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- cpu_req, input, 1, request valid. Held high with stable fields until cpu_ready.
- cpu_we, input, 1, 1 = store, 0 = load.
- cpu_addr, input, ADDRESS_WIDTH, word address.
- cpu_wdata, input, DATA_WIDTH, store data.
- cpu_ready, output, 1, one-cycle completion pulse.
- cpu_rdata, output, DATA_WIDTH, load data. Valid when cpu_ready=1 and cpu_we=0.
- mem_addr, output, ADDRESS_WIDTH, block address (offset bits 0) during fill; word address during write.
- mem_read_data, input, DATA_WIDTH*BLOCK_WORDS, block. Word i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- mem_write_data, output, DATA_WIDTH, write-through data.
- mem_write_enable, output, 1, one-cycle write strobe.
- hit_count, output, 32, load hits since reset. Saturating.
- miss_count, output, 32, load misses since reset. Saturating.

Behaviour:
- Interface convention: one clock (clk). Reset rst_n is asynchronous and active-low.
- Address split:
  - offset = cpu_addr[OFFSET_BITS-1:0]
  - index = next INDEX_BITS bits
  - tag = remaining upper bits
- Storage per line: valid bit, tag, BLOCK_WORDS data words.
- Reset (asserted at any time, including mid-fill or mid-write):
  - State goes to IDLE and all valid bits clear.
  - cpu_ready=0, cpu_rdata=0, mem_addr=0, mem_write_data=0, mem_write_enable=0.
  - Counters are cleared.
  - An aborted fill installs nothing.
- Tag/data arrays need no reset.
- States: IDLE, FILL, RESPOND, WRITE.
- IDLE, cpu_req=0: no action.
- IDLE, load hit (valid and tag match):
  - Go to RESPOND.
  - Register the selected word into cpu_rdata.
  - hit_count increments.
- IDLE, load miss:
  - Go to FILL.
  - mem_addr = {tag, index, 0}.
  - Latency counter loads MISS_LATENCY-1.
  - miss_count increments.
- IDLE, store:
  - Go to WRITE.
  - Register mem_addr=cpu_addr and mem_write_data=cpu_wdata.
- FILL:
  - mem_addr is held.
  - Counter decrements each cycle.
  - At counter 0: capture mem_read_data into the line, set its valid bit, write the tag, register word[offset] into cpu_rdata, go to RESPOND.
- RESPOND: cpu_ready=1 for exactly this cycle, then IDLE.
- WRITE:
  - mem_write_enable=1 and cpu_ready=1 for exactly this cycle, then IDLE.
  - On a tag hit, the cached word is updated in the same edge.
  - On a miss, the cache is unchanged (no allocate).
- Latency:
  - Load hit: cpu_ready 2 cycles after cpu_req is sampled in IDLE.
  - Load miss: cpu_ready MISS_LATENCY+2 cycles after cpu_req is sampled in IDLE.
  - Store: cpu_ready 2 cycles after cpu_req is sampled in IDLE.
- Back-to-back requests: after cpu_ready, at least one IDLE cycle elapses before the next request is sampled.
- mem_write_enable is never high outside WRITE.
- mem_addr is stable for the whole FILL.
- A fill evicts any valid line at that index. The line is clean, so no writeback.
- cpu_rdata holds its last value outside RESPOND.
- Counters stop at 2**32-1. Stores are not counted.

Test Plan:
- Reset, then load addr 0x0000005 with memory block 0x4 = {0xDD,0xCC,0xBB,0xAA} (word3..word0):
  - Miss.
  - mem_addr=0x0000004 held for 2 cycles.
  - cpu_ready at cycle 4 with cpu_rdata=0xBB.
  - miss_count=1.
- Then load 0x0000007: hit, cpu_rdata=0xDD at cycle 2, no mem_addr change, hit_count=1.
- Store 0x0000006 data 0x12345678 (line resident):
  - mem_write_enable pulses once with mem_addr=0x0000006 and mem_write_data=0x12345678.
  - A subsequent load 0x0000006 hits and returns 0x12345678.
- Store to non-resident 0x0000100, then load 0x0000100:
  - The write goes to memory.
  - The load misses (miss_count increments) and fills from memory.
- Conflict: load 0x0000004, then load 0x0000044 (same index 1, different tag), then 0x0000004: three misses, each a full fill.
- Assert rst_n=0 during the second FILL cycle, release, then load the same address:
  - All outputs read 0 during reset.
  - The load misses (the line was not installed).
  - Counters restart from 0.
